// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle between the pipeline requesters, the arbiter and the unified memory.
interface unified_mem_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  // Fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              if_stall;
  // Data port
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;
  logic              d_stall;
  // Pipeline control and status
  logic              hold;
  logic              owner;
  logic              busy;
  // Memory side
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter view
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, hold, mem_rdata,
    output if_rdata, if_ready, if_stall, d_rdata, d_ready, d_stall,
           owner, busy, mem_en, mem_we, mem_addr, mem_wdata
  );

  // Pipeline/memory environment view
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, hold, mem_rdata,
    input  if_rdata, if_ready, if_stall, d_rdata, d_ready, d_stall,
           owner, busy, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Arbitrates the IF and MEM stages onto one single-port memory.
// Each access runs IDLE -> ACCESS -> [WAIT x MEM_LAT] -> RESP; writes skip WAIT.
module unified_mem_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int MEM_LAT  = 1,
  parameter int FAIRNESS = 4
) (
  input logic                  clk,
  input logic                  Reset,
  unified_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  localparam logic [3:0] LatLast = 4'(MEM_LAT - 1);
  localparam logic [3:0] FairMax = 4'(FAIRNESS);

  state_t            state;
  logic [3:0]        waitCnt;
  logic [3:0]        fairCnt;
  logic              memEn;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWdata;
  logic [DATA_W-1:0] ifRdata;
  logic [DATA_W-1:0] dRdata;
  logic              ifReady;
  logic              dReady;
  logic              ownerQ;
  logic              busyQ;
  logic              grantData;
  logic              grantFetch;

  // Grant decision in IDLE: data has priority until fetch has waited FAIRNESS grants
  always_comb begin
    grantData  = 1'b0;
    grantFetch = 1'b0;
    if (state == IDLE && !bus.hold) begin
      if (bus.d_req && !(bus.if_req && fairCnt == FairMax)) grantData = 1'b1;
      else if (bus.if_req)                                  grantFetch = 1'b1;
    end
  end

  // Access sequencer with registered memory strobes, ready pulses and status
  always_ff @(posedge clk) begin
    if (Reset) begin
      state    <= IDLE;
      waitCnt  <= '0;
      fairCnt  <= '0;
      memEn    <= 1'b0;
      memWe    <= 1'b0;
      memAddr  <= '0;
      memWdata <= '0;
      ifRdata  <= '0;
      dRdata   <= '0;
      ifReady  <= 1'b0;
      dReady   <= 1'b0;
      ownerQ   <= 1'b0;
      busyQ    <= 1'b0;
    end else begin
      memEn   <= 1'b0;
      memWe   <= 1'b0;
      ifReady <= 1'b0;
      dReady  <= 1'b0;
      case (state)
        IDLE: begin
          if (!bus.if_req) fairCnt <= '0;
          if (grantData) begin
            memAddr  <= bus.d_addr;
            memWdata <= bus.d_wdata;
            memWe    <= bus.d_we;
            memEn    <= 1'b1;
            ownerQ   <= 1'b1;
            busyQ    <= 1'b1;
            state    <= ACCESS;
            if (bus.if_req && fairCnt != FairMax) fairCnt <= fairCnt + 4'd1;
          end else if (grantFetch) begin
            memAddr <= bus.if_addr;
            memEn   <= 1'b1;
            ownerQ  <= 1'b0;
            busyQ   <= 1'b1;
            fairCnt <= '0;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          // memWe still holds the granted direction during this cycle
          waitCnt <= LatLast;
          if (memWe) begin
            state <= RESP;
            if (ownerQ) dReady  <= 1'b1;
            else        ifReady <= 1'b1;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (waitCnt == '0) begin
            state <= RESP;
            if (ownerQ) begin
              dRdata <= bus.mem_rdata;
              dReady <= 1'b1;
            end else begin
              ifRdata <= bus.mem_rdata;
              ifReady <= 1'b1;
            end
          end else begin
            waitCnt <= waitCnt - 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
          busyQ <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_en    = memEn;
  assign bus.mem_we    = memWe;
  assign bus.mem_addr  = memAddr;
  assign bus.mem_wdata = memWdata;
  assign bus.if_rdata  = ifRdata;
  assign bus.d_rdata   = dRdata;
  assign bus.if_ready  = ifReady;
  assign bus.d_ready   = dReady;
  assign bus.owner     = ownerQ;
  assign bus.busy      = busyQ;
  assign bus.if_stall  = bus.if_req & ~ifReady;
  assign bus.d_stall   = bus.d_req & ~dReady;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Randomized bench for unified_mem_arbiter against a transaction-level timing model.
module tb_unified_mem_arbiter;
  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int LAT  = 3;
  localparam int FAIR = 4;

  logic clk = 1'b0;
  logic Reset = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  unified_mem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  unified_mem_arbiter #(
    .DATA_W(DW), .ADDR_W(AW), .MEM_LAT(LAT), .FAIRNESS(FAIR)
  ) dut (
    .clk(clk), .Reset(Reset), .bus(bus)
  );

  always #5 clk = ~clk;

  // cycle index, advanced at every active edge
  always @(posedge clk) cyc <= cyc + 1;

  // Reference state: the current/last granted transaction and its cycle schedule
  int          accessCyc = -10;
  int          respCyc   = -10;
  int          nextIdle  = 0;
  int          fairCnt   = 0;
  logic        gOwner    = 1'b0;
  logic        gWe       = 1'b0;
  logic [31:0] gAddr     = '0;
  logic [31:0] gData     = '0;
  logic [31:0] gRead     = '0;
  logic        mOwner    = 1'b0;
  logic [31:0] expIfRd   = '0;
  logic [31:0] expDRd    = '0;
  logic [31:0] refMem [16];
  // Memory behaviour seen by the DUT
  logic [31:0] memArr [16];
  int          rdPendCyc = -10;
  logic [31:0] rdPendData = '0;
  // Requester state
  bit ifPend = 0, ifGranted = 0, dPend = 0, dGranted = 0;
  // Stimulus knobs (percent)
  int pReq = 0, pWr = 0, pHold = 0, pRst = 0;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] rndAddr();
    return $urandom() & 32'hFFF0_003C;
  endfunction

  task automatic modelReset(input int c);
    accessCyc = -10;
    respCyc   = -10;
    nextIdle  = c + 1;
    fairCnt   = 0;
    mOwner    = 1'b0;
    expIfRd   = '0;
    expDRd    = '0;
    rdPendCyc = -10;
    ifGranted = 0;
    dGranted  = 0;
  endtask

  task automatic stepCycle();
    int c;
    bit expEn, expIfRdy, expDRdy;
    c = cyc;
    // results of a read become visible in its response cycle
    if (c == respCyc && !gWe) begin
      if (gOwner) expDRd = gRead;
      else        expIfRd = gRead;
    end
    expEn    = (c == accessCyc);
    expIfRdy = (c == respCyc) && !gOwner;
    expDRdy  = (c == respCyc) && gOwner;

    checkEq("busy", bus.busy, 32'(c >= accessCyc && c <= respCyc));
    checkEq("mem_en", bus.mem_en, 32'(expEn));
    checkEq("mem_we", bus.mem_we, 32'(expEn && gWe));
    if (expEn) begin
      checkEq("mem_addr", bus.mem_addr, gAddr);
      if (gWe) checkEq("mem_wdata", bus.mem_wdata, gData);
    end
    checkEq("if_ready", bus.if_ready, 32'(expIfRdy));
    checkEq("d_ready", bus.d_ready, 32'(expDRdy));
    checkEq("owner", bus.owner, 32'(mOwner));
    checkEq("if_rdata", bus.if_rdata, expIfRd);
    checkEq("d_rdata", bus.d_rdata, expDRd);

    // memory: commit writes, return read data exactly LAT cycles after mem_en
    if (bus.mem_en) begin
      if (bus.mem_we) memArr[bus.mem_addr[5:2]] = bus.mem_wdata;
      else begin
        rdPendCyc  = c + LAT;
        rdPendData = memArr[bus.mem_addr[5:2]];
      end
    end
    bus.mem_rdata = (c == rdPendCyc) ? rdPendData : $urandom();

    // requesters: finish on the modelled ready, then maybe issue anew
    if (c == respCyc) begin
      if (gOwner) begin dPend = 0; dGranted = 0; end
      else begin ifPend = 0; ifGranted = 0; end
    end
    if (!ifPend && $urandom_range(0, 99) < pReq) begin
      ifPend = 1;
      bus.if_addr = rndAddr();
    end else if (ifPend && ifGranted) begin
      bus.if_addr = rndAddr();
    end
    if (!dPend && $urandom_range(0, 99) < pReq) begin
      dPend = 1;
      bus.d_addr  = rndAddr();
      bus.d_wdata = $urandom();
      bus.d_we    = ($urandom_range(0, 99) < pWr);
    end else if (dPend && dGranted) begin
      bus.d_addr  = rndAddr();
      bus.d_wdata = $urandom();
      bus.d_we    = $urandom_range(0, 1) == 1;
    end
    bus.if_req = ifPend;
    bus.d_req  = dPend;
    bus.hold   = ($urandom_range(0, 99) < pHold);
    if ($urandom_range(0, 99) < pRst) begin
      Reset = 1'b1;
      modelReset(c);
    end else begin
      Reset = 1'b0;
    end

    #1;
    checkEq("if_stall", bus.if_stall, 32'(ifPend && !expIfRdy));
    checkEq("d_stall", bus.d_stall, 32'(dPend && !expDRdy));

    // arbitration in an idle cycle
    if (!Reset && c >= nextIdle) begin
      bit takeD;
      if (!ifPend) fairCnt = 0;
      if (!bus.hold && (ifPend || dPend)) begin
        takeD     = dPend && !(ifPend && fairCnt == FAIR);
        gOwner    = takeD;
        mOwner    = takeD;
        accessCyc = c + 1;
        if (takeD) begin
          gWe   = bus.d_we;
          gAddr = bus.d_addr;
          gData = bus.d_wdata;
          dGranted = 1;
          if (ifPend) fairCnt = (fairCnt < FAIR) ? fairCnt + 1 : FAIR;
        end else begin
          gWe   = 1'b0;
          gAddr = bus.if_addr;
          ifGranted = 1;
          fairCnt = 0;
        end
        if (gWe) begin
          refMem[gAddr[5:2]] = gData;
          respCyc = c + 2;
        end else begin
          gRead   = refMem[gAddr[5:2]];
          respCyc = c + LAT + 2;
        end
        nextIdle = respCyc + 1;
      end
    end
  endtask

  task automatic runPhase(input int n, input int req, input int wr, input int hld, input int rst);
    pReq = req; pWr = wr; pHold = hld; pRst = rst;
    repeat (n) begin
      @(negedge clk);
      stepCycle();
    end
  endtask

  initial begin
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.hold = 1'b0; bus.mem_rdata = '0;
    for (int i = 0; i < 16; i++) begin
      refMem[i] = $urandom();
      memArr[i] = refMem[i];
    end
    repeat (3) @(negedge clk);
    modelReset(cyc);
    runPhase(800, 60, 40, 0, 0);
    runPhase(300, 100, 0, 0, 0);
    runPhase(400, 80, 50, 60, 0);
    runPhase(800, 70, 40, 10, 3);
    runPhase(200, 30, 50, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port unified memory between two requesters: the IF stage (instruction fetch, read-only) and the MEM stage (data load/store).
- Sequences each access through a small FSM, holds the memory latency, and returns data with a one-cycle ready pulse.
- Drives per-port stall outputs to the pipeline hazard logic.
- Replaces the separate instruction and data memory instances once the CPU moves to a single memory.

Parameters:
- DATA_W, 32, data width
- ADDR_W, 32, address width
- MEM_LAT, 1, read latency in cycles from the mem_en cycle to mem_rdata valid (legal range 1..15)
- FAIRNESS, 4, maximum consecutive data grants while a fetch is waiting (legal range 1..15)

Ports:
- clk  in  1  clock
- Reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held until if_ready
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetch data, valid while if_ready=1
- if_ready  out  1  one-cycle completion pulse for fetch
- if_stall  out  1  if_req & ~if_ready (combinational)
- d_req  in  1  data request; held until d_ready
- d_we  in  1  1=store, 0=load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data, valid while d_ready=1
- d_ready  out  1  one-cycle completion pulse for data
- d_stall  out  1  d_req & ~d_ready (combinational)
- hold  in  1  blocks new grants; in-flight access completes
- mem_en  out  1  memory access strobe, registered
- mem_we  out  1  memory write enable, registered
- mem_addr  out  ADDR_W  registered
- mem_wdata  out  DATA_W  registered
- mem_rdata  in  DATA_W  memory read data
- owner  out  1  owner of the current or last access: 0=fetch, 1=data
- busy  out  1  1 whenever state != IDLE

Behaviour:
- States: IDLE, ACCESS, WAIT, RESP.
- Reset: state=IDLE; mem_en, mem_we, if_ready, d_ready, busy, owner and the fairness counter all 0; mem_addr, mem_wdata, if_rdata and d_rdata all 0.
- Reset mid-access: the transaction is discarded with no ready pulse, and the requester must keep or reissue its request.
- IDLE, hold=1: no grant.
- IDLE, hold=0, one request: grant it.
- IDLE, hold=0, both requesting: data wins unless fair_cnt==FAIRNESS, in which case fetch wins.
- On grant: latch addr, we (fetch forces we=0) and wdata into mem_* registers, set owner, go to ACCESS. Requester input changes after the grant are ignored until its ready pulse.
- ACCESS (exactly 1 cycle): mem_en=1.
  - Write: memory commits this cycle; next state RESP.
  - Read: next state WAIT.
- WAIT: lasts MEM_LAT cycles (4-bit down-counter). mem_rdata is captured into the owner's rdata register at the end of the last WAIT cycle; next state RESP.
- RESP (1 cycle): the owner's ready=1 and rdata stable; the non-owner's ready=0; next state IDLE.
  - A requester whose req is still high in the IDLE cycle after its ready pulse is treated as a new request.
- Latency, with req first seen in IDLE at cycle T:
  - Read: ready in cycle T+MEM_LAT+2.
  - Write: ready in cycle T+2.
  - Minimum spacing between grants: MEM_LAT+3 cycles for reads, 3 cycles for writes.
- Fairness counter, updated at each grant:
  - Data grant with if_req=1: fair_cnt += 1, saturating at FAIRNESS.
  - Fetch grant: fair_cnt cleared.
  - IDLE cycle with if_req=0: fair_cnt cleared.
- mem_en and mem_we are 0 outside ACCESS. mem_addr and mem_wdata hold their last values.
- rdata registers hold their value until the next read for the same port.
- Fetch write: impossible, since fetch forces we=0.

Test Plan:
- Reset, then if_req=1, if_addr=0x10, MEM_LAT=1, memory returns 0xDEADBEEF → mem_en=1 only in cycle T+1; if_ready=1 in cycle T+3 with if_rdata=0xDEADBEEF; if_stall=1 in cycles T..T+2.
- d_req=1, d_we=1, d_addr=0x20, d_wdata=0x55AA → mem_we=1 with addr 0x20 in cycle T+1; d_ready in cycle T+2; no WAIT state entered.
- if_req and d_req both held continuously, data loads only, FAIRNESS=4 → grant order D,D,D,D,F,D,D,D,D,F; owner observed matching that order.
- Reset asserted in a WAIT cycle of a fetch → next cycle is IDLE, no if_ready pulse, all outputs 0; reissued fetch completes normally.
- hold=1 with both requests pending for 5 cycles → no mem_en and busy=0 throughout; hold released → data granted the following cycle.
- MEM_LAT=3 read of 0x1234 → if_ready exactly 5 cycles after the request, and capture occurs on the third WAIT cycle.
